aforo_carril: RTL

Parametrised occupancy controller for one lane watched by two sensors, A on the outside and B on the inside. A built-in direction-decoding FSM turns A/B beam sequences into entry and exit events. A saturating occupancy counter with full, empty and almost-full flags tracks those events. It replaces the fixed 3-bit direction-decoder/counter pair and sits between the debounce stage and the LED/display logic.

---
 rtl/aforo_carril.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/aforo_carril.sv
// Lane occupancy controller: decodes A/B beam sequences into entry/exit events and
// keeps a saturating occupancy count. Optional stall timeout guarded by AFORO_TIMEOUT_EN.
module aforo_carril #(
   parameter int  CAPACITY      = 7,
   parameter int  ALMOST_MARGIN = 1,
   parameter int  TIMEOUT_CYC   = 12000,
   localparam int CW            = $clog2(CAPACITY + 1)
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          A,
   input  logic          B,
   input  logic          clear,
   output logic [CW-1:0] count,
   output logic          full,
   output logic          empty,
   output logic          almost_full,
   output logic          entry,
   output logic          exit_ev,
   output logic          reject,
   output logic          underflow,
   output logic          timeout,
   output logic [2:0]    state
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_E1   = 3'd1;
   localparam logic [2:0] S_E2   = 3'd2;
   localparam logic [2:0] S_E3   = 3'd3;
   localparam logic [2:0] S_X1   = 3'd4;
   localparam logic [2:0] S_X2   = 3'd5;
   localparam logic [2:0] S_X3   = 3'd6;
   localparam logic [2:0] S_WCLR = 3'd7;

   localparam logic [CW-1:0] CAP_C = CW'(CAPACITY);
   localparam logic [CW-1:0] AF_C  = CW'(CAPACITY - ALMOST_MARGIN);

   generate
      if (CAPACITY < 1 || CAPACITY > 1023) begin : g_bad_capacity
         $error("aforo_carril: CAPACITY must be within 1..1023");
      end
      if (ALMOST_MARGIN < 0 || ALMOST_MARGIN >= CAPACITY) begin : g_bad_margin
         $error("aforo_carril: ALMOST_MARGIN must be below CAPACITY");
      end
      if (TIMEOUT_CYC < 1) begin : g_bad_timeout
         $error("aforo_carril: TIMEOUT_CYC must be at least 1");
      end
   endgenerate

   logic          a_reg;
   logic          b_reg;
   logic [1:0]    ab;
   logic [2:0]    state_reg;
   logic [2:0]    state_next;
   logic [2:0]    fsm_next;
   logic          done_entry;
   logic          done_exit;
   logic [CW-1:0] count_reg;
   logic [CW-1:0] count_next;
   logic          full_reg;
   logic          empty_reg;
   logic          almost_full_reg;
   logic          entry_reg;
   logic          entry_next;
   logic          exit_reg;
   logic          exit_next;
   logic          reject_reg;
   logic          reject_next;
   logic          underflow_reg;
   logic          underflow_next;

   // Single input register; the debounce stage upstream already cleans the sensors.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         a_reg <= 1'b0;
         b_reg <= 1'b0;
      end else begin
         a_reg <= A;
         b_reg <= B;
      end
   end

   assign ab = {a_reg, b_reg};

   // Direction decoder: entry walks 10-11-01-00, exit walks 01-11-10-00.
   always_comb begin
      fsm_next   = state_reg;
      done_entry = 1'b0;
      done_exit  = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (ab == 2'b10)      fsm_next = S_E1;
            else if (ab == 2'b01) fsm_next = S_X1;
         end
         S_E1: begin
            case (ab)
               2'b10:   fsm_next = S_E1;
               2'b11:   fsm_next = S_E2;
               default: fsm_next = S_IDLE;
            endcase
         end
         S_E2: begin
            case (ab)
               2'b11:   fsm_next = S_E2;
               2'b01:   fsm_next = S_E3;
               2'b10:   fsm_next = S_E1;
               default: fsm_next = S_IDLE;
            endcase
         end
         S_E3: begin
            case (ab)
               2'b01:   fsm_next = S_E3;
               2'b11:   fsm_next = S_E2;
               2'b10:   fsm_next = S_IDLE;
               default: begin
                  fsm_next   = S_IDLE;
                  done_entry = 1'b1;
               end
            endcase
         end
         S_X1: begin
            case (ab)
               2'b01:   fsm_next = S_X1;
               2'b11:   fsm_next = S_X2;
               default: fsm_next = S_IDLE;
            endcase
         end
         S_X2: begin
            case (ab)
               2'b11:   fsm_next = S_X2;
               2'b10:   fsm_next = S_X3;
               2'b01:   fsm_next = S_X1;
               default: fsm_next = S_IDLE;
            endcase
         end
         S_X3: begin
            case (ab)
               2'b10:   fsm_next = S_X3;
               2'b11:   fsm_next = S_X2;
               2'b01:   fsm_next = S_IDLE;
               default: begin
                  fsm_next  = S_IDLE;
                  done_exit = 1'b1;
               end
            endcase
         end
         S_WCLR: begin
            if (ab == 2'b00) fsm_next = S_IDLE;
         end
         default: fsm_next = S_IDLE;
      endcase
   end

`ifdef AFORO_TIMEOUT_EN
   localparam int SW = $clog2(TIMEOUT_CYC + 1);

   logic [SW-1:0] stall_reg;
   logic [SW-1:0] stall_next;
   logic          stall_hit;
   logic          timeout_reg;

   // The stall count only runs while a sequence sits in one partial state.
   always_comb begin
      stall_next = '0;
      stall_hit  = 1'b0;
      if (state_reg != S_IDLE && state_reg != S_WCLR && fsm_next == state_reg) begin
         if (stall_reg == SW'(TIMEOUT_CYC - 1)) stall_hit = 1'b1;
         else                                   stall_next = stall_reg + 1'b1;
      end
      state_next = stall_hit ? S_WCLR : fsm_next;
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         stall_reg   <= '0;
         timeout_reg <= 1'b0;
      end else begin
         stall_reg   <= stall_next;
         timeout_reg <= stall_hit;
      end
   end

   assign timeout = timeout_reg;
`else
   always_comb begin
      state_next = fsm_next;
   end

   assign timeout = 1'b0;
`endif

   // clear wins over any same-cycle increment/decrement but the completion still pulses.
   always_comb begin
      count_next     = count_reg;
      entry_next     = 1'b0;
      exit_next      = 1'b0;
      reject_next    = 1'b0;
      underflow_next = 1'b0;
      if (done_entry) begin
         if (clear) begin
            entry_next = 1'b1;
         end else if (count_reg < CAP_C) begin
            count_next = count_reg + 1'b1;
            entry_next = 1'b1;
         end else begin
            reject_next = 1'b1;
         end
      end
      if (done_exit) begin
         if (clear) begin
            exit_next = 1'b1;
         end else if (count_reg != '0) begin
            count_next = count_reg - 1'b1;
            exit_next  = 1'b1;
         end else begin
            underflow_next = 1'b1;
         end
      end
      if (clear) count_next = '0;
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_reg       <= S_IDLE;
         count_reg       <= '0;
         full_reg        <= 1'b0;
         empty_reg       <= 1'b1;
         almost_full_reg <= 1'b0;
         entry_reg       <= 1'b0;
         exit_reg        <= 1'b0;
         reject_reg      <= 1'b0;
         underflow_reg   <= 1'b0;
      end else begin
         state_reg       <= state_next;
         count_reg       <= count_next;
         full_reg        <= (count_next == CAP_C);
         empty_reg       <= (count_next == '0);
         almost_full_reg <= (count_next >= AF_C);
         entry_reg       <= entry_next;
         exit_reg        <= exit_next;
         reject_reg      <= reject_next;
         underflow_reg   <= underflow_next;
      end
   end

   assign count       = count_reg;
   assign full        = full_reg;
   assign empty       = empty_reg;
   assign almost_full = almost_full_reg;
   assign entry       = entry_reg;
   assign exit_ev     = exit_reg;
   assign reject      = reject_reg;
   assign underflow   = underflow_reg;
   assign state       = state_reg;

endmodule
